yarp_unified_mem: RTL and testbench



---
 rtl/yarp_unified_mem.sv | 164 ++++++++++++++++
 tb/tb_yarp_unified_mem.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_unified_mem.sv
// Single-ported unified instruction/data memory for the YARP core.
// Grants one access per cycle and returns responses after RD_LAT cycles.
module yarp_unified_mem #(
    parameter int DEPTH      = 1024,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        instr_mem_req,
    input  logic [31:0] instr_mem_addr,
    output logic        instr_mem_gnt,
    output logic        instr_mem_rvalid,
    output logic [31:0] instr_mem_rd_data,
    output logic        instr_mem_err,

    input  logic        data_mem_req,
    input  logic [31:0] data_mem_addr,
    input  logic [1:0]  data_mem_byte_en,
    input  logic        data_mem_wr,
    input  logic [31:0] data_mem_wr_data,
    output logic        data_mem_gnt,
    output logic        data_mem_rvalid,
    output logic [31:0] data_mem_rd_data,
    output logic        data_mem_err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [3:0]    r_starve_cnt;

    logic          w_starved;
    logic [AW-1:0] w_i_idx;
    logic          w_i_err;
    logic [AW-1:0] w_d_idx;
    logic [1:0]    w_d_lane;
    logic          w_d_err;
    logic [3:0]    w_d_be;
    logic [31:0]   w_d_wdata;
    logic [AW-1:0] w_rd_idx;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_rd_shift;
    logic [31:0]   w_ld_data;
    logic [31:0]   w_i_in_data;
    logic [31:0]   w_d_in_data;
    logic          w_unused;

    // Response pipelines, stage 1 is loaded at the accept edge.
    logic [RD_LAT:1] r_i_vld;
    logic [RD_LAT:1] r_i_err;
    logic [31:0]     r_i_data [1:RD_LAT];
    logic [RD_LAT:1] r_d_vld;
    logic [RD_LAT:1] r_d_err;
    logic [31:0]     r_d_data [1:RD_LAT];

    assign w_starved = (r_starve_cnt == 4'(STARVE_MAX));

    // Data has priority unless the fetch port has waited STARVE_MAX cycles.
    assign instr_mem_gnt = ~reset & instr_mem_req & (~data_mem_req | w_starved);
    assign data_mem_gnt  = ~reset & data_mem_req & ~(instr_mem_req & w_starved);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (instr_mem_req && !instr_mem_gnt) begin
            if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end

    assign w_i_idx  = instr_mem_addr[AW+1:2];
    assign w_i_err  = |instr_mem_addr[1:0];
    assign w_d_idx  = data_mem_addr[AW+1:2];
    assign w_d_lane = data_mem_addr[1:0];
    assign w_unused = ^{instr_mem_addr[31:AW+2], data_mem_addr[31:AW+2]};

    always_comb begin
        w_d_err = 1'b0;
        w_d_be  = 4'b0000;
        case (data_mem_byte_en)
            2'b00: w_d_be = 4'b0001 << w_d_lane;
            2'b01: begin
                w_d_err = w_d_lane[0];
                w_d_be  = 4'b0011 << w_d_lane;
            end
            2'b11: begin
                w_d_err = |w_d_lane;
                w_d_be  = 4'b1111;
            end
            default: w_d_err = 1'b1;
        endcase
    end

    assign w_d_wdata = data_mem_wr_data << {w_d_lane, 3'b000};

    // Stores commit at the accept edge, so a later load sees them.
    always_ff @(posedge clk) begin
        if (data_mem_gnt && data_mem_wr && !w_d_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_d_be[b]) begin
                    r_mem[w_d_idx][8*b +: 8] <= w_d_wdata[8*b +: 8];
                end
            end
        end
    end

    assign w_rd_idx   = instr_mem_gnt ? w_i_idx : w_d_idx;
    assign w_rd_word  = r_mem[w_rd_idx];
    assign w_rd_shift = w_rd_word >> {w_d_lane, 3'b000};

    always_comb begin
        w_ld_data = 32'd0;
        case (data_mem_byte_en)
            2'b00:   w_ld_data = {24'd0, w_rd_shift[7:0]};
            2'b01:   w_ld_data = {16'd0, w_rd_shift[15:0]};
            2'b11:   w_ld_data = w_rd_shift;
            default: w_ld_data = 32'd0;
        endcase
    end

    assign w_i_in_data = (instr_mem_gnt && !w_i_err) ? w_rd_word : 32'd0;
    assign w_d_in_data = (data_mem_gnt && !data_mem_wr && !w_d_err) ? w_ld_data : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i_vld <= '0;
            r_i_err <= '0;
            r_d_vld <= '0;
            r_d_err <= '0;
            for (int s = 1; s <= RD_LAT; s++) begin
                r_i_data[s] <= 32'd0;
                r_d_data[s] <= 32'd0;
            end
        end else begin
            r_i_vld[1]  <= instr_mem_gnt;
            r_i_err[1]  <= instr_mem_gnt & w_i_err;
            r_i_data[1] <= w_i_in_data;
            r_d_vld[1]  <= data_mem_gnt;
            r_d_err[1]  <= data_mem_gnt & w_d_err;
            r_d_data[1] <= w_d_in_data;
            for (int s = 2; s <= RD_LAT; s++) begin
                r_i_vld[s]  <= r_i_vld[s-1];
                r_i_err[s]  <= r_i_err[s-1];
                r_i_data[s] <= r_i_data[s-1];
                r_d_vld[s]  <= r_d_vld[s-1];
                r_d_err[s]  <= r_d_err[s-1];
                r_d_data[s] <= r_d_data[s-1];
            end
        end
    end

    assign instr_mem_rvalid  = r_i_vld[RD_LAT];
    assign instr_mem_err     = r_i_err[RD_LAT];
    assign instr_mem_rd_data = r_i_data[RD_LAT];
    assign data_mem_rvalid   = r_d_vld[RD_LAT];
    assign data_mem_err      = r_d_err[RD_LAT];
    assign data_mem_rd_data  = r_d_data[RD_LAT];

endmodule

// File: tb/tb_yarp_unified_mem.sv
// Bench for yarp_unified_mem: two instances (RD_LAT 1 and 3) share one stimulus stream;
// expected responses are queued with their due cycle and checked by a monitor.
module tb_yarp_unified_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [31:0] da;
    logic [1:0]  dbe;
    logic        dwr;
    logic [31:0] dwd;

    logic        l1_ignt, l1_irv, l1_ierr, l1_dgnt, l1_drv, l1_derr;
    logic [31:0] l1_ird, l1_drd;
    logic        l3_ignt, l3_irv, l3_ierr, l3_dgnt, l3_drv, l3_derr;
    logic [31:0] l3_ird, l3_drd;

    yarp_unified_mem #(.DEPTH(1024), .RD_LAT(1), .STARVE_MAX(4)) u_lat1 (
        .clk(clk), .reset(reset),
        .instr_mem_req(ir), .instr_mem_addr(ia), .instr_mem_gnt(l1_ignt),
        .instr_mem_rvalid(l1_irv), .instr_mem_rd_data(l1_ird), .instr_mem_err(l1_ierr),
        .data_mem_req(dr), .data_mem_addr(da), .data_mem_byte_en(dbe), .data_mem_wr(dwr),
        .data_mem_wr_data(dwd), .data_mem_gnt(l1_dgnt), .data_mem_rvalid(l1_drv),
        .data_mem_rd_data(l1_drd), .data_mem_err(l1_derr)
    );

    yarp_unified_mem #(.DEPTH(1024), .RD_LAT(3), .STARVE_MAX(4)) u_lat3 (
        .clk(clk), .reset(reset),
        .instr_mem_req(ir), .instr_mem_addr(ia), .instr_mem_gnt(l3_ignt),
        .instr_mem_rvalid(l3_irv), .instr_mem_rd_data(l3_ird), .instr_mem_err(l3_ierr),
        .data_mem_req(dr), .data_mem_addr(da), .data_mem_byte_en(dbe), .data_mem_wr(dwr),
        .data_mem_wr_data(dwd), .data_mem_gnt(l3_dgnt), .data_mem_rvalid(l3_drv),
        .data_mem_rd_data(l3_drd), .data_mem_err(l3_derr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Entry: {due cycle[30:0], err, data}
    logic [63:0] exp_i1_q[$];
    logic [63:0] exp_d1_q[$];
    logic [63:0] exp_i3_q[$];
    logic [63:0] exp_d3_q[$];

    function automatic logic [63:0] mk(input int due, input logic err, input logic [31:0] d);
        logic [31:0] due_v;
        due_v = due;
        return {due_v[30:0], err, d};
    endfunction

    task automatic check_resp(input string nm, input logic [63:0] e, input int c,
                              input logic err, input logic [31:0] d);
        logic [31:0] c_v;
        c_v = c;
        checks++;
        if (e[63:33] != c_v[30:0] || e[32] !== err || e[31:0] !== d) begin
            errors++;
            $display("FAIL %s: got cyc=%0d err=%0b data=%08h, expected cyc=%0d err=%0b data=%08h",
                     nm, c, err, d, e[63:33], e[32], e[31:0]);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] d);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected rvalid data=%08h at cyc=%0d, expected no response",
                 nm, d, cyc);
    endtask

    // Monitor: pops the scoreboard whenever a response appears.
    always @(negedge clk) begin
        if (l1_irv) begin
            if (exp_i1_q.size() == 0) unexpected("lat1_instr", l1_ird);
            else check_resp("lat1_instr", exp_i1_q.pop_front(), cyc, l1_ierr, l1_ird);
        end
        if (l1_drv) begin
            if (exp_d1_q.size() == 0) unexpected("lat1_data", l1_drd);
            else check_resp("lat1_data", exp_d1_q.pop_front(), cyc, l1_derr, l1_drd);
        end
        if (l3_irv) begin
            if (exp_i3_q.size() == 0) unexpected("lat3_instr", l3_ird);
            else check_resp("lat3_instr", exp_i3_q.pop_front(), cyc, l3_ierr, l3_ird);
        end
        if (l3_drv) begin
            if (exp_d3_q.size() == 0) unexpected("lat3_data", l3_drd);
            else check_resp("lat3_data", exp_d3_q.pop_front(), cyc, l3_derr, l3_drd);
        end
        if (!reset) begin
            checks++;
            if ((l1_ignt && l1_dgnt) || (l3_ignt && l3_dgnt) ||
                l1_ignt !== l3_ignt || l1_dgnt !== l3_dgnt) begin
                errors++;
                $display("FAIL gnt_excl: got l1 i/d=%0b%0b l3 i/d=%0b%0b, expected one-hot and equal",
                         l1_ignt, l1_dgnt, l3_ignt, l3_dgnt);
            end
        end
    end

    task automatic push_d(input int c, input logic e, input logic [31:0] d, input bit to3);
        exp_d1_q.push_back(mk(c + 1, e, d));
        if (to3) exp_d3_q.push_back(mk(c + 3, e, d));
    endtask

    task automatic push_i(input int c, input logic e, input logic [31:0] d);
        exp_i1_q.push_back(mk(c + 1, e, d));
        exp_i3_q.push_back(mk(c + 3, e, d));
    endtask

    // Drivers start right after a rising edge and return right after the accept edge.
    task automatic data_op(input logic wr, input logic [1:0] be, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                           input bit to3);
        bit granted;
        granted = 1'b0;
        dr = 1'b1; dwr = wr; dbe = be; da = addr; dwd = wd;
        for (int t = 0; t < 20 && !granted; t++) begin
            @(negedge clk);
            if (l1_dgnt) granted = 1'b1;
        end
        if (!granted) begin
            checks++;
            errors++;
            $display("FAIL data_gnt_timeout: got no gnt for addr %08h, expected gnt", addr);
        end else begin
            push_d(cyc, exp_e, exp_d, to3);
        end
        @(posedge clk);
        #1;
        dr = 1'b0;
    endtask

    task automatic instr_op(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e);
        bit granted;
        granted = 1'b0;
        ir = 1'b1; ia = addr;
        for (int t = 0; t < 20 && !granted; t++) begin
            @(negedge clk);
            if (l1_ignt) granted = 1'b1;
        end
        if (!granted) begin
            checks++;
            errors++;
            $display("FAIL instr_gnt_timeout: got no gnt for addr %08h, expected gnt", addr);
        end else begin
            push_i(cyc, exp_e, exp_d);
        end
        @(posedge clk);
        #1;
        ir = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ir = 1'b1; ia = 32'h0;
        dr = 1'b1; da = 32'h0; dbe = 2'b11; dwr = 1'b0; dwd = 32'h0;

        // Outputs idle and grants suppressed while reset is held with requests up.
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (l1_ignt || l1_dgnt || l3_ignt || l3_dgnt ||
                l1_irv || l1_drv || l3_irv || l3_drv ||
                l1_ierr || l1_derr || l3_ierr || l3_derr ||
                l1_ird != 0 || l1_drd != 0 || l3_ird != 0 || l3_drd != 0) begin
                errors++;
                $display("FAIL reset_outputs: got gnt/rvalid/err/data activity, expected all 0");
            end
        end
        @(posedge clk);
        #1;
        ir = 1'b0; dr = 1'b0; reset = 1'b0;

        // Word store then load.
        data_op(1'b1, 2'b11, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        data_op(1'b0, 2'b11, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

        // Sub-word store and loads.
        data_op(1'b1, 2'b11, 32'h40, 32'h11223344, 32'h0, 1'b0, 1'b1);
        data_op(1'b1, 2'b00, 32'h43, 32'h000000A5, 32'h0, 1'b0, 1'b1);
        data_op(1'b0, 2'b11, 32'h40, 32'h0, 32'hA5223344, 1'b0, 1'b1);
        data_op(1'b0, 2'b01, 32'h42, 32'h0, 32'h0000A522, 1'b0, 1'b1);
        data_op(1'b0, 2'b00, 32'h43, 32'h0, 32'h000000A5, 1'b0, 1'b1);

        // Misaligned and reserved-size accesses; word 0x40 must survive.
        data_op(1'b0, 2'b01, 32'h41, 32'h0, 32'h0, 1'b1, 1'b1);
        data_op(1'b1, 2'b11, 32'h42, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        data_op(1'b1, 2'b10, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1);
        data_op(1'b0, 2'b10, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1);
        data_op(1'b0, 2'b11, 32'h40, 32'h0, 32'hA5223344, 1'b0, 1'b1);
        instr_op(32'h102, 32'h0, 1'b1);

        // Preload words 0x00..0x1C, then eight back-to-back fetches.
        for (int i = 0; i < 8; i++) begin
            data_op(1'b1, 2'b11, 32'(i * 4), 32'hC0DE0000 | 32'(i), 32'h0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            instr_op(32'(i * 4), 32'hC0DE0000 | 32'(i), 1'b0);
        end

        // Both ports request continuously: expect D D D D I repeating.
        ia = 32'h4; da = 32'h40; dbe = 2'b11; dwr = 1'b0;
        ir = 1'b1; dr = 1'b1;
        for (int n = 0; n < 10; n++) begin
            bit exp_i;
            @(negedge clk);
            exp_i = (n % 5 == 4);
            checks++;
            if (l1_ignt !== exp_i || l1_dgnt !== !exp_i) begin
                errors++;
                $display("FAIL starve_gnt[%0d]: got i=%0b d=%0b, expected i=%0b d=%0b",
                         n, l1_ignt, l1_dgnt, exp_i, !exp_i);
            end
            if (exp_i) push_i(cyc, 1'b0, 32'hC0DE0001);
            else       push_d(cyc, 1'b0, 32'hA5223344, 1'b1);
            @(posedge clk);
            #1;
        end
        ir = 1'b0; dr = 1'b0;

        // Aliasing: 0x1000 maps onto word 0 with DEPTH 1024.
        data_op(1'b1, 2'b11, 32'h1000, 32'h55AA55AA, 32'h0, 1'b0, 1'b1);
        data_op(1'b0, 2'b11, 32'h0, 32'h0, 32'h55AA55AA, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Reset one cycle after a load is accepted: only the RD_LAT=1 copy responds.
        data_op(1'b0, 2'b11, 32'h40, 32'h0, 32'hA5223344, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        data_op(1'b0, 2'b11, 32'h0, 32'h0, 32'h55AA55AA, 1'b0, 1'b1);

        repeat (6) @(negedge clk);
        checks++;
        if (exp_i1_q.size() != 0 || exp_d1_q.size() != 0 ||
            exp_i3_q.size() != 0 || exp_d3_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got pending i1=%0d d1=%0d i3=%0d d3=%0d, expected all 0",
                     exp_i1_q.size(), exp_d1_q.size(), exp_i3_q.size(), exp_d3_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
